// File: rtl/aes_dec_arbiter.sv
// aes_dec_arbiter: round-robin share of one AES-256 decipher core by two requesters.
// Define AES_DEC_ARB_STATS_EN to add per-requester completion counters.
module aes_dec_arbiter #(
  parameter int unsigned CORE_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [255:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [255:0] req1_key,
  output logic [127:0] core_datain,
  output logic [255:0] core_key,
  input  logic [127:0] core_dataout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
`ifdef AES_DEC_ARB_STATS_EN
  ,
  output logic [15:0]  done_cnt0,
  output logic [15:0]  done_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_grant;
  logic       win;
  logic       acc;

  assign busy = (state != IDLE);

  // Only a tie consults last_grant; a lone requester always wins.
  always_comb begin
    unique case (1'b1)
      (req0_valid && req1_valid): win = ~last_grant;
      default:                    win = req1_valid;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    acc        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          acc        = 1'b1;
          req0_ready = ~win;
          req1_ready = win;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      core_datain <= '0;
      core_key    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        core_datain <= win ? req1_data : req0_data;
        core_key    <= win ? req1_key : req0_key;
        rsp_id      <= win;
        last_grant  <= win;
        cnt         <= 4'(CORE_LATENCY - 1);
      end
      if (state == WAIT) begin
        if (cnt == 4'd0) begin
          rsp_data  <= core_dataout;
          rsp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef AES_DEC_ARB_STATS_EN
  logic hs;
  assign hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0 <= 16'd0;
      done_cnt1 <= 16'd0;
    end else if (hs) begin
      if (!rsp_id && done_cnt0 != 16'hFFFF) done_cnt0 <= done_cnt0 + 16'd1;
      if (rsp_id && done_cnt1 != 16'hFFFF) done_cnt1 <= done_cnt1 + 16'd1;
    end
  end
`endif

endmodule
